// File: rtl/row_fetch_unit.sv
// Row fetch sequencer: walks NROWS row pairs from a dual-port RAM, absorbs the
// one-cycle read latency in a 2-entry FIFO and streams them over valid/ready.
module row_fetch_unit #(
  parameter  int unsigned ADDR_WIDTH = 10,
  parameter  int unsigned ROW_BYTES  = 8,
  parameter  int unsigned NROWS      = 8,
  localparam int unsigned ROW_BITS   = 8 * ROW_BYTES,
  localparam int unsigned IDX_W      = (NROWS > 1) ? $clog2(NROWS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_a_i,
  input  logic [ADDR_WIDTH-1:0] base_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic                  en_a_o,
  output logic                  en_b_o,
  input  logic [ROW_BITS-1:0]   rdata_a_i,
  input  logic [ROW_BITS-1:0]   rdata_b_i,
  output logic                  row_valid_o,
  input  logic                  row_ready_i,
  output logic [ROW_BITS-1:0]   row_a_o,
  output logic [ROW_BITS-1:0]   row_b_o,
  output logic [IDX_W-1:0]      row_idx_o,
  output logic                  row_last_o
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(NROWS + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(ROW_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_next_a;
  logic [ADDR_WIDTH-1:0] r_next_b;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_pending;
  logic                  r_busy;
  logic                  r_done;
  logic [ROW_BITS-1:0]   r_mem_a [FIFO_DEPTH];
  logic [ROW_BITS-1:0]   r_mem_b [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic w_valid;
  logic w_xfer;
  logic w_issue_ok;
  logic w_last_issue;
  logic w_last_xfer;
  logic w_start;
  logic w_issue;
  logic w_finish;

  assign w_valid      = (r_count != 2'd0);
  assign w_xfer       = w_valid && row_ready_i;
  // Popping this cycle frees a slot for the read that lands two cycles later.
  assign w_issue_ok   = ((r_count + 2'(r_pending)) < 2'(FIFO_DEPTH)) || w_xfer;
  assign w_last_issue = (r_issue_cnt == CNT_W'(NROWS - 1));
  assign w_last_xfer  = w_xfer && (r_idx == IDX_W'(NROWS - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)                    w_state_nxt = S_FETCH;
      S_FETCH: if (w_issue && w_last_issue)    w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_xfer)                w_state_nxt = S_IDLE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // FSM decoded controls; start is blocked during the done cycle
  always_comb begin
    w_start  = 1'b0;
    w_issue  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_start  = start_i && !r_done;
      S_FETCH: w_issue  = w_issue_ok;
      S_DRAIN: w_finish = w_last_xfer;
      default: ;
    endcase
  end

  // Sequencing registers: bases, counters, status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_next_a    <= '0;
      r_next_b    <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_issue_cnt <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_busy    <= (w_state_nxt != S_IDLE) || w_finish;
      r_pending <= w_issue;
      if (w_start) begin
        r_next_a    <= base_a_i & ALIGN_MASK;
        r_next_b    <= base_b_i & ALIGN_MASK;
        r_issue_cnt <= '0;
        r_idx       <= '0;
      end else begin
        if (w_issue) begin
          r_addr_a    <= r_next_a;
          r_addr_b    <= r_next_b;
          r_next_a    <= r_next_a + ADDR_WIDTH'(ROW_BYTES);
          r_next_b    <= r_next_b + ADDR_WIDTH'(ROW_BYTES);
          r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
        if (w_xfer) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Two-entry row FIFO written one cycle after each issue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem_a[i] <= '0;
        r_mem_b[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_pending) begin
        r_mem_a[r_wr_ptr] <= rdata_a_i;
        r_mem_b[r_wr_ptr] <= rdata_b_i;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_xfer) r_rd_ptr <= ~r_rd_ptr;
      case ({r_pending, w_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign en_a_o      = w_issue;
  assign en_b_o      = w_issue;
  assign addr_a_o    = w_issue ? r_next_a : r_addr_a;
  assign addr_b_o    = w_issue ? r_next_b : r_addr_b;
  assign row_valid_o = w_valid;
  assign row_a_o     = r_mem_a[r_rd_ptr];
  assign row_b_o     = r_mem_b[r_rd_ptr];
  assign row_idx_o   = r_idx;
  assign row_last_o  = w_valid && (r_idx == IDX_W'(NROWS - 1));

endmodule

// File: tb/tb_row_fetch_unit.sv
// Testbench for row_fetch_unit: RAM model plus a cycle-level behavioural
// reference (issue/delivery bookkeeping) checked on every clock.
module tb_row_fetch_unit;

  localparam int unsigned AW    = 10;
  localparam int unsigned RB    = 8;
  localparam int unsigned NR    = 8;
  localparam int unsigned RBITS = 64;
  localparam int          NMEM  = 128;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [AW-1:0]    base_a_i = '0;
  logic [AW-1:0]    base_b_i = '0;
  logic             busy_o, done_o, en_a_o, en_b_o;
  logic [AW-1:0]    addr_a_o, addr_b_o;
  logic [RBITS-1:0] rdata_a_i, rdata_b_i;
  logic             row_valid_o;
  logic             row_ready_i = 1'b0;
  logic [RBITS-1:0] row_a_o, row_b_o;
  logic [2:0]       row_idx_o;
  logic             row_last_o;

  row_fetch_unit #(.ADDR_WIDTH(AW), .ROW_BYTES(RB), .NROWS(NR)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .base_a_i(base_a_i), .base_b_i(base_b_i),
    .busy_o(busy_o), .done_o(done_o),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
    .en_a_o(en_a_o), .en_b_o(en_b_o),
    .rdata_a_i(rdata_a_i), .rdata_b_i(rdata_b_i),
    .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .row_a_o(row_a_o), .row_b_o(row_b_o),
    .row_idx_o(row_idx_o), .row_last_o(row_last_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAM with one-cycle read latency, indexed by row
  logic [63:0] mem [NMEM];
  always @(posedge clk) begin
    if (en_a_o) rdata_a_i <= mem[int'(addr_a_o) / int'(RB)];
    if (en_b_o) rdata_b_i <= mem[int'(addr_b_o) / int'(RB)];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] ram_row(input int byte_addr);
    return mem[(byte_addr % (1 << AW)) / int'(RB)];
  endfunction

  // Reference model state
  bit      m_busy = 0, m_done = 0, m_run = 0;
  int      m_issued = 0, m_xfer = 0;
  int      m_icyc [NR];
  int      m_base_a = 0, m_base_b = 0;
  logic [AW-1:0] m_addr_a = '0, m_addr_b = '0;

  int   t0 = 1 << 30;
  bit   rec_en [64], rec_valid [64], rec_last [64], rec_done [64];
  logic [63:0] rec_addr_a [64], rec_addr_b [64], rec_row_a [64], rec_row_b [64];

  task automatic compare_cycle();
    bit exp_valid, xfer, exp_en, nd, accept;
    int occ, rel;
    logic [AW-1:0] ea, eb;
    if (!rst_ni) begin
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_en_a", 64'(en_a_o), 64'd0);
      check("rst_en_b", 64'(en_b_o), 64'd0);
      check("rst_addr_a", 64'(addr_a_o), 64'd0);
      check("rst_addr_b", 64'(addr_b_o), 64'd0);
      check("rst_valid", 64'(row_valid_o), 64'd0);
      check("rst_row_a", row_a_o, 64'd0);
      check("rst_row_b", row_b_o, 64'd0);
      check("rst_idx", 64'(row_idx_o), 64'd0);
      check("rst_last", 64'(row_last_o), 64'd0);
      m_busy = 0; m_done = 0; m_run = 0; m_issued = 0; m_xfer = 0;
      m_addr_a = '0; m_addr_b = '0;
      return;
    end
    occ = m_issued - m_xfer;
    exp_valid = 0;
    if (m_run && m_xfer < m_issued) exp_valid = (m_icyc[m_xfer] <= cyc - 2);
    xfer   = exp_valid && row_ready_i;
    exp_en = m_run && (m_issued < int'(NR)) && (occ < 2 || xfer);
    ea = m_addr_a;
    eb = m_addr_b;
    if (exp_en) begin
      ea = AW'(m_base_a + int'(RB) * m_issued);
      eb = AW'(m_base_b + int'(RB) * m_issued);
    end
    check("en_a", 64'(en_a_o), 64'(exp_en));
    check("en_b", 64'(en_b_o), 64'(exp_en));
    check("addr_a", 64'(addr_a_o), 64'(ea));
    check("addr_b", 64'(addr_b_o), 64'(eb));
    check("valid", 64'(row_valid_o), 64'(exp_valid));
    check("busy", 64'(busy_o), 64'(m_busy));
    check("done", 64'(done_o), 64'(m_done));
    if (exp_valid) begin
      check("row_a", row_a_o, ram_row(m_base_a + int'(RB) * m_xfer));
      check("row_b", row_b_o, ram_row(m_base_b + int'(RB) * m_xfer));
      check("row_idx", 64'(row_idx_o), 64'(m_xfer));
      check("row_last", 64'(row_last_o), 64'(m_xfer == int'(NR) - 1));
    end
    rel = cyc - t0;
    if (rel >= 0 && rel < 64) begin
      rec_en[rel] = en_a_o;       rec_valid[rel] = row_valid_o;
      rec_last[rel] = row_last_o; rec_done[rel] = done_o;
      rec_addr_a[rel] = 64'(addr_a_o); rec_addr_b[rel] = 64'(addr_b_o);
      rec_row_a[rel] = row_a_o;   rec_row_b[rel] = row_b_o;
    end
    if (exp_en) begin
      m_icyc[m_issued] = cyc;
      m_issued++;
      m_addr_a = ea;
      m_addr_b = eb;
    end
    if (xfer) m_xfer++;
    nd = xfer && (m_xfer == int'(NR));
    accept = !m_busy && start_i;
    if (m_done) m_busy = 0;
    if (nd) m_run = 0;
    if (accept) begin
      m_busy = 1; m_run = 1; m_issued = 0; m_xfer = 0;
      m_base_a = (int'(base_a_i) / int'(RB)) * int'(RB);
      m_base_b = (int'(base_b_i) / int'(RB)) * int'(RB);
    end
    m_done = nd;
  endtask

  initial forever begin
    @(negedge clk);
    compare_cycle();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rdy(input int mode, input int rel);
    if (mode == 0) return 1'b1;
    if (mode == 1) return rel >= 13;
    return ($urandom_range(0, 1) == 1);
  endfunction

  // One operation; optional second start at extra_at, optional reset at rst_at
  task automatic run_op(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                        input int mode, input int extra_at, input int rst_at);
    bit seen, aborted;
    seen = 0; aborted = 0;
    base_a_i = ba; base_b_i = bb;
    start_i = 1'b1;
    row_ready_i = rdy(mode, 0);
    t0 = cyc;
    step();
    for (int rel = 1; rel < 400 && !seen && !aborted; rel++) begin
      row_ready_i = rdy(mode, rel);
      start_i = (rel == extra_at);
      if (rel == extra_at) begin base_a_i = 10'h200; base_b_i = 10'h280; end
      if (rel == rst_at) begin
        rst_ni = 1'b0;
        #1;
        check("rst_now_busy", 64'(busy_o), 64'd0);
        check("rst_now_en", 64'(en_a_o), 64'd0);
        check("rst_now_valid", 64'(row_valid_o), 64'd0);
        check("rst_now_addr", 64'(addr_a_o), 64'd0);
        check("rst_now_idx", 64'(row_idx_o), 64'd0);
        start_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        aborted = 1;
      end else begin
        if (done_o) seen = 1;
        step();
      end
    end
    start_i = 1'b0;
    if (!aborted) begin
      check("done_seen", 64'(seen), 64'd1);
      step();
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < NMEM; i++)
      mem[i] = (i >= 32 && i < 64) ? 64'h2000 + 64'(i - 32) : 64'h1000 + 64'(i);
    repeat (3) step();
    rst_ni = 1'b1;
    step();

    // Streaming, ready held high
    run_op(10'h000, 10'h100, 0, -1, -1);
    check("s_en1", 64'(rec_en[1]), 64'd1);
    check("s_addr1", rec_addr_a[1], 64'h000);
    check("s_addr8", rec_addr_a[8], 64'h038);
    check("s_valid2", 64'(rec_valid[2]), 64'd0);
    check("s_valid3", 64'(rec_valid[3]), 64'd1);
    check("s_rowa3", rec_row_a[3], 64'h1000);
    check("s_rowb3", rec_row_b[3], 64'h2000);
    check("s_last10", 64'(rec_last[10]), 64'd1);
    check("s_rowa10", rec_row_a[10], 64'h1007);
    check("s_done11", 64'(rec_done[11]), 64'd1);
    check("s_valid11", 64'(rec_valid[11]), 64'd0);

    // Back-pressure until cycle 13
    run_op(10'h000, 10'h100, 1, -1, -1);
    n = 0;
    for (int i = 0; i < 13; i++) n += int'(rec_en[i]);
    check("bp_issues", 64'(n), 64'd2);
    check("bp_en13", 64'(rec_en[13]), 64'd1);
    check("bp_addr13", rec_addr_a[13], 64'h010);

    // Random ready
    for (int k = 0; k < 3; k++) run_op(10'h000, 10'h100, 2, -1, -1);

    // Address wrap
    run_op(10'h3F8, 10'h100, 0, -1, -1);
    check("w_addr1", rec_addr_a[1], 64'h3F8);
    check("w_addr2", rec_addr_a[2], 64'h000);
    check("w_addr3", rec_addr_a[3], 64'h008);
    check("w_row3", rec_row_a[3], 64'h107F);
    check("w_row4", rec_row_a[4], 64'h1000);
    check("w_row5", rec_row_a[5], 64'h1001);

    // Unaligned base and an ignored second start
    run_op(10'h000, 10'h10D, 0, 5, -1);
    check("u_addrb1", rec_addr_b[1], 64'h108);
    check("u_rowb3", rec_row_b[3], 64'h2001);
    check("u_addra8", rec_addr_a[8], 64'h038);

    // Reset mid-operation, then a clean run
    run_op(10'h000, 10'h100, 0, -1, 6);
    step();
    run_op(10'h040, 10'h100, 0, -1, -1);
    check("r_valid3", 64'(rec_valid[3]), 64'd1);
    check("r_rowa3", rec_row_a[3], 64'h1008);

    // Random bases with random ready
    for (int k = 0; k < 4; k++) run_op(AW'($urandom), AW'($urandom), 2, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
